// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer handlers.
// Functions work on a 16-bit container; callers zero-extend and truncate.
package fifo_ptr_pkg;

    localparam int PTR_WIDTH_DEF = 4;
    localparam int AF_MARGIN_DEF = 2;
    localparam int PTR_MAX_W     = 16;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended high bits leave the low bits of the result unaffected.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of parametrised width.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [fifo_ptr_pkg::PTR_MAX_W-1:0] bin_full;

    assign bin_full = fifo_ptr_pkg::gray2bin(fifo_ptr_pkg::PTR_MAX_W'(gray));
    assign bin      = bin_full[W-1:0];

endmodule

// File: rtl/wptr_ctrl.sv
// Write-side pointer handler of an async FIFO: binary/Gray write pointer,
// full/almost_full, write-side level, write ack and sticky overflow.
module wptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int AF_MARGIN = AF_MARGIN_DEF
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_en,
    input  logic [PTR_WIDTH-1:0] g_rptr_sync,
    input  logic                 ovf_clr,
    output logic [PTR_WIDTH-1:0] b_wptr,
    output logic [PTR_WIDTH-1:0] g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH-1:0] wr_level,
    output logic                 wr_ack,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH:0]   DEPTH_W   = (PTR_WIDTH+1)'(1) << (PTR_WIDTH-1);
    localparam logic [PTR_WIDTH:0]   AF_W      = (PTR_WIDTH+1)'(AF_MARGIN);
    // Full when the write Gray pointer equals the read one with its top two bits inverted.
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(2'b11) << (PTR_WIDTH-2);

    logic [PTR_WIDTH-1:0] b_rptr;
    logic [PTR_WIDTH-1:0] b_wptr_d, b_wptr_q;
    logic [PTR_WIDTH-1:0] g_wptr_d, g_wptr_q;
    logic [PTR_WIDTH-1:0] level_d, level_q;
    logic [PTR_WIDTH:0]   free_slots;
    logic                 full_d, full_q;
    logic                 af_d, af_q;
    logic                 ack_d, ack_q;
    logic                 ovf_d, ovf_q;
    logic                 wr_acc;

    gray2bin #(.W(PTR_WIDTH)) u_rptr_g2b (
        .gray (g_rptr_sync),
        .bin  (b_rptr)
    );

    always_comb begin
        wr_acc     = w_en & ~full_q;
        b_wptr_d   = b_wptr_q + PTR_WIDTH'(wr_acc);
        g_wptr_d   = PTR_WIDTH'(bin2gray(PTR_MAX_W'(b_wptr_d)));
        full_d     = (g_wptr_d == (g_rptr_sync ^ FULL_MASK));
        level_d    = b_wptr_d - b_rptr;
        free_slots = DEPTH_W - {1'b0, level_d};
        af_d       = (free_slots <= AF_W);
        ack_d      = wr_acc;
        // A fresh overflow attempt takes priority over a clear request.
        ovf_d      = (w_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            b_wptr_q <= b_wptr_d;
            g_wptr_q <= g_wptr_d;
            full_q   <= full_d;
            af_q     <= af_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
        end
    end

    assign b_wptr      = b_wptr_q;
    assign g_wptr      = g_wptr_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign wr_ack      = ack_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl: directed scenarios plus random traffic
// against a count-based model of the FIFO write side.
module tb_wptr_ctrl;

    localparam int PW    = 4;
    localparam int DEPTH = 8;
    localparam int AFM   = 2;

    logic          w_clk = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic [PW-1:0] g_rptr_sync = '0;
    logic          ovf_clr = 1'b0;
    logic [PW-1:0] b_wptr, g_wptr, wr_level;
    logic          full, almost_full, wr_ack, overflow;

    wptr_ctrl #(.PTR_WIDTH(PW), .AF_MARGIN(AFM)) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_en        (w_en),
        .g_rptr_sync (g_rptr_sync),
        .ovf_clr     (ovf_clr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .wr_ack      (wr_ack),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    int total = 0;
    int bad   = 0;

    // Model: total writes accepted and total reads seen, both unbounded.
    int wc, rc;
    bit m_full, m_af, m_ack, m_ovf;

    function automatic logic [PW-1:0] gray(input int v);
        int m;
        m = v % 16;
        return PW'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int lvl;
        lvl = (wc - rc) % 16;
        chk({ph, ":b_wptr"},   32'(b_wptr),      32'(wc % 16));
        chk({ph, ":g_wptr"},   32'(g_wptr),      32'(gray(wc)));
        chk({ph, ":full"},     32'(full),        32'(m_full));
        chk({ph, ":afull"},    32'(almost_full), 32'(m_af));
        chk({ph, ":level"},    32'(wr_level),    32'(lvl));
        chk({ph, ":ack"},      32'(wr_ack),      32'(m_ack));
        chk({ph, ":overflow"}, 32'(overflow),    32'(m_ovf));
    endtask

    task automatic model_reset();
        wc = 0; rc = 0;
        m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0;
    endtask

    // One clock: drive at negedge, model the edge, check 1 time unit after it.
    task automatic step(input string ph, input bit we, input int r, input bit clr);
        bit acc;
        int lvl;
        @(negedge w_clk);
        w_en = we; rc = r; g_rptr_sync = gray(r); ovf_clr = clr;
        @(posedge w_clk);
        acc   = we && !m_full;
        m_ovf = (we && m_full) || (m_ovf && !clr);
        if (acc) wc++;
        m_ack  = acc;
        lvl    = (wc - rc) % 16;
        m_full = (lvl == DEPTH);
        m_af   = ((DEPTH - lvl) <= AFM);
        #1;
        check_all(ph);
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rst_n = 1'b0; w_en = 1'b1; ovf_clr = 1'b0; g_rptr_sync = '0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge w_clk);
        #1;
        check_all("rst_held");
        @(negedge w_clk);
        w_rst_n = 1'b1; w_en = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] prev_g;
        int r;
        model_reset();
        #1;
        check_all("por");
        do_reset();

        // Fill from empty with the reader idle.
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 0, 1'b0);
        chk("fill_bw_const", 32'(b_wptr), 32'h8);
        chk("fill_gw_const", 32'(g_wptr), 32'hC);
        chk("fill_full",     32'(full),   32'h1);

        // Overflow attempts, clear alone, clear against a new attempt.
        step("ovf", 1'b1, 0, 1'b0);
        step("ovf", 1'b1, 0, 1'b0);
        chk("ovf_bw_hold", 32'(b_wptr), 32'h8);
        step("ovf_clr", 1'b0, 0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'h0);
        step("ovf_setwin", 1'b1, 0, 1'b1);
        chk("ovf_setwins", 32'(overflow), 32'h1);
        step("ovf_clr2", 1'b0, 0, 1'b1);

        // Read advance while writing into a full FIFO.
        step("radv", 1'b1, 1, 1'b0);
        step("radv", 1'b1, 1, 1'b0);
        chk("radv_full",  32'(full),     32'h1);
        chk("radv_level", 32'(wr_level), 32'h8);

        // Walk the reader to Gray(8) so the writer wraps 1111 -> 0000.
        for (int k = 2; k <= 8; k++) begin
            for (int j = 0; j < 2; j++) begin
                prev_g = g_wptr;
                step("wrap", 1'b1, k, 1'b0);
                chk("wrap_gray_1bit", 32'($countones(prev_g ^ g_wptr) <= 1), 32'h1);
            end
        end
        chk("wrap_bw_zero", 32'(b_wptr),      32'h0);
        chk("wrap_rptr",    32'(g_rptr_sync), 32'hC);
        chk("wrap_full",    32'(full),        32'h1);
        step("wrap_clr", 1'b0, 8, 1'b1);

        // Random traffic; the reader never passes the writer.
        for (int n = 0; n < 400; n++) begin
            r = rc;
            if ($urandom_range(0, 2) != 0 && rc < wc) r = rc + 1;
            step("rand", 1'($urandom_range(0, 1)), r, ($urandom_range(0, 7) == 0));
        end

        // Reset between edges with level 5 and a write in flight.
        do_reset();
        for (int i = 0; i < 5; i++) step("pre_mid", 1'b1, 0, 1'b0);
        chk("mid_level5", 32'(wr_level), 32'h5);
        @(negedge w_clk);
        w_en = 1'b1;
        @(posedge w_clk);
        #2;
        w_rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        @(negedge w_clk);
        w_rst_n = 1'b1; w_en = 1'b0;
        @(posedge w_clk);
        #1;
        check_all("post_rst");
        chk("post_rst_noack", 32'(wr_ack), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wptr_ctrl.md
WPTR_CTRL -- requirements
Module: wptr_ctrl

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 4, meaning pointer width = log2(DEPTH)+1; DEPTH = 2**(PTR_WIDTH-1); legal range 2..16.
REQ-002 SHALL have parameter AF_MARGIN, default 2, meaning almost_full asserts when free slots <= AF_MARGIN; legal range 1..DEPTH-1.
REQ-003 SHALL have port w_clk  input  1  write-domain clock, the only clock.
REQ-004 SHALL have port w_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port w_en  input  1  write request.
REQ-006 SHALL have port g_rptr_sync  input  PTR_WIDTH  Gray read pointer, already synchronised into w_clk.
REQ-007 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port b_wptr  output  PTR_WIDTH  binary write pointer (RAM address = low PTR_WIDTH-1 bits).
REQ-009 SHALL have port g_wptr  output  PTR_WIDTH  Gray write pointer, to the read-domain synchroniser.
REQ-010 SHALL have port full  output  1  FIFO full.
REQ-011 SHALL have port almost_full  output  1  free slots <= AF_MARGIN.
REQ-012 SHALL have port wr_level  output  PTR_WIDTH  occupancy as seen from write side, 0..DEPTH.
REQ-013 SHALL have port wr_ack  output  1  one-cycle pulse, previous-cycle write accepted.
REQ-014 SHALL have port overflow  output  1  sticky, a write was attempted while full.

Function
REQ-015 Write accept: wr_acc = w_en & ~full, evaluated at each rising w_clk.
REQ-016 On wr_acc, b_wptr SHALL increment by 1 modulo 2**PTR_WIDTH; otherwise b_wptr holds.
REQ-017 g_wptr SHALL be registered as (b_wptr_next >> 1) ^ b_wptr_next, updating on the same edge as b_wptr.
REQ-018 full SHALL be registered: full_next = (g_wptr_next == {~g_rptr_sync[MSB:MSB-1], g_rptr_sync[MSB-2:0]}).
REQ-019 b_rptr SHALL be derived combinationally from g_rptr_sync by Gray-to-binary conversion.
REQ-020 wr_level SHALL be registered as (b_wptr_next - b_rptr) mod 2**PTR_WIDTH; never exceeds DEPTH.
REQ-021 almost_full SHALL be registered as (DEPTH - level_next) <= AF_MARGIN; it is 1 whenever full is 1.
REQ-022 wr_ack SHALL equal wr_acc delayed one cycle; no ack for a rejected write.
REQ-023 w_en & full SHALL leave all pointers unchanged and set overflow on that edge.
REQ-024 overflow SHALL clear on an edge with ovf_clr=1 only if no new overflow occurs that edge; set wins over clear.
REQ-025 Pointer wrap (b_wptr 2**PTR_WIDTH-1 -> 0) SHALL produce no glitch in g_wptr (single-bit change) and no false full.
REQ-026 Read-pointer advance in the same cycle as an accepted write SHALL be reflected: flags use the new g_rptr_sync and b_wptr_next together.
REQ-027 full and level are pessimistic by the synchroniser latency; no correction SHALL be attempted.

Reset
REQ-028 w_rst_n=0 SHALL immediately, without a clock edge, force b_wptr=0, g_wptr=0, full=0, almost_full=0, wr_level=0, wr_ack=0, overflow=0.
REQ-029 Deassertion SHALL be recognised on the next w_clk edge; w_en sampled during reset is ignored.
REQ-030 Reset asserted mid-write SHALL discard the in-flight write; no wr_ack follows.

Structure
REQ-031 Package fifo_ptr_pkg SHALL hold bin2gray/gray2bin functions and default PTR_WIDTH/AF_MARGIN constants, shared with the read-side handler.
REQ-032 One sub-module gray2bin (parametrised width, combinational) SHALL convert g_rptr_sync; all other logic stays in wptr_ctrl.
REQ-033 All outputs SHALL come directly from flops.

Verification (PTR_WIDTH=4, AF_MARGIN=2, g_rptr_sync=0 unless stated)
REQ-034 Reset release, w_en=1 for 8 cycles -> wr_level 1..8, almost_full=1 at level 6, full=1 with b_wptr=4'b1000, g_wptr=4'b1100.
REQ-035 Full, w_en=1 two more cycles -> b_wptr stays 4'b1000, wr_ack=0, overflow=1; ovf_clr pulse alone -> overflow=0; ovf_clr during an overflow attempt -> overflow stays 1.
REQ-036 Wrap: step g_rptr_sync through Gray(8..15) while writing -> b_wptr 4'b1111->4'b0000, g_wptr changes one bit per step, full=1 exactly at b_wptr=0000 with g_rptr_sync=Gray(8)=4'b1100.
REQ-037 Full, then g_rptr_sync advances to Gray(1) with w_en=1 same cycle -> one write accepted, full stays 1, wr_level=8.
REQ-038 Assert w_rst_n=0 between clock edges at level 5 -> all outputs 0 before next edge; no wr_ack after release.
